// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit addressed I2C target, open-drain SDA only, with synchronised and glitch-filtered pins.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h48,
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);
  typedef enum logic [2:0] {IDLE, ADDR, AACK, WRITE, WACK, READ, RACK, IGNORE} state_t;
  logic [1:0] s1, s2, f, fq;
  logic [3:0] fc [2];
  logic scl_rise, scl_fall, start_c, stop_c, rw, sda_oe;
  logic [6:0] sr;
  logic [2:0] cnt;
  state_t state;
  assign sda = sda_oe ? 1'b0 : 1'bz;
  // bit 1 carries scl, bit 0 carries sda; filtered value moves after FILTER_LEN agreeing samples
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= '1;
      s2 <= '1;
      f <= '1;
      fq <= '1;
      fc[0] <= '0;
      fc[1] <= '0;
    end else begin
      s1 <= {scl, sda};
      s2 <= s1;
      fq <= f;
      for (int i = 0; i < 2; i++)
        if (s2[i] == f[i]) fc[i] <= '0;
        else if (fc[i] == 4'(FILTER_LEN - 1)) begin
          f[i] <= s2[i];
          fc[i] <= '0;
        end else fc[i] <= fc[i] + 4'd1;
    end
  assign scl_rise = f[1] & ~fq[1];
  assign scl_fall = ~f[1] & fq[1];
  assign start_c = f[1] & fq[1] & fq[0] & ~f[0];
  assign stop_c = f[1] & fq[1] & ~fq[0] & f[0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      rw <= 1'b0;
      sda_oe <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_first <= 1'b0;
      tx_req <= 1'b0;
      busy <= 1'b0;
      start_det <= 1'b0;
      stop_det <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req <= 1'b0;
      start_det <= 1'b0;
      stop_det <= 1'b0;
      if (rx_valid) rx_first <= 1'b0;
      if (start_c) begin
        state <= ADDR;
        cnt <= 3'd7;
        sda_oe <= 1'b0;
        start_det <= 1'b1;
      end else if (stop_c) begin
        state <= IDLE;
        sda_oe <= 1'b0;
        stop_det <= 1'b1;
        busy <= 1'b0;
      end else
        case (state)
          ADDR: if (scl_rise) begin
            sr <= {sr[5:0], f[0]};
            cnt <= cnt - 3'd1;
            if (cnt == 3'd0) begin
              rw <= f[0];
              state <= (sr == SLAVE_ADDR) ? AACK : IGNORE;
              if (sr == SLAVE_ADDR) busy <= 1'b1;
            end
          end
          // sda_oe tells the ACK-bit fall (drive) apart from the fall that ends it
          AACK: if (scl_rise && sda_oe && rw) tx_req <= 1'b1;
          else if (scl_fall) begin
            if (!sda_oe) sda_oe <= 1'b1;
            else if (rw) begin
              sr <= tx_data[6:0];
              sda_oe <= ~tx_data[7];
              cnt <= 3'd7;
              state <= READ;
            end else begin
              sda_oe <= 1'b0;
              cnt <= 3'd7;
              rx_first <= 1'b1;
              state <= WRITE;
            end
          end
          WRITE: if (scl_rise) begin
            sr <= {sr[5:0], f[0]};
            cnt <= cnt - 3'd1;
            if (cnt == 3'd0) begin
              rx_data <= {sr, f[0]};
              rx_valid <= 1'b1;
              state <= WACK;
            end
          end
          WACK: if (scl_fall) begin
            sda_oe <= ~sda_oe;
            if (sda_oe) begin
              cnt <= 3'd7;
              state <= WRITE;
            end
          end
          READ: if (scl_fall) begin
            if (cnt == 3'd0) begin
              sda_oe <= 1'b0;
              state <= RACK;
            end else begin
              sr <= {sr[5:0], 1'b0};
              sda_oe <= ~sr[6];
              cnt <= cnt - 3'd1;
            end
          end
          RACK: if (scl_rise) begin
            if (f[0]) state <= IGNORE;
            else tx_req <= 1'b1;
          end else if (scl_fall) begin
            sr <= tx_data[6:0];
            sda_oe <= ~tx_data[7];
            cnt <= 3'd7;
            state <= READ;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bus-master sequences against i2c_slave with hand-computed expectations.
module tb_i2c_slave;
  localparam int Q = 10;
  logic clk = 0, reset = 1, scl = 1, m_sda = 1;
  logic [7:0] tx_data = 8'h00;
  wire sda;
  logic [7:0] rx_data;
  logic rx_valid, rx_first, tx_req, busy, start_det, stop_det;
  int n_rx = 0, n_tx = 0, n_st = 0, n_sp = 0;
  int b_rx, b_tx, b_st, b_sp;
  int total = 0, fails = 0;
  logic [7:0] rx_log [8];
  logic rxf_log [8];
  logic a, s;
  logic [7:0] d;

  i2c_slave dut (.clk(clk), .reset(reset), .scl(scl), .sda(sda), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_first(rx_first), .tx_req(tx_req), .tx_data(tx_data),
    .busy(busy), .start_det(start_det), .stop_det(stop_det));

  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[n_rx % 8] <= rx_data;
      rxf_log[n_rx % 8] <= rx_first;
      n_rx <= n_rx + 1;
    end
    if (tx_req) n_tx <= n_tx + 1;
    if (start_det) n_st <= n_st + 1;
    if (stop_det) n_sp <= n_sp + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap;
    b_rx = n_rx;
    b_tx = n_tx;
    b_st = n_st;
    b_sp = n_sp;
  endtask

  task automatic bitc(input logic b, output logic smp);
    m_sda = b;
    wc(Q);
    scl = 1;
    wc(Q);
    smp = sda;
    wc(Q);
    scl = 0;
    wc(Q);
  endtask

  task automatic i2c_start;
    m_sda = 1;
    wc(Q);
    scl = 1;
    wc(Q);
    m_sda = 0;
    wc(Q);
    scl = 0;
    wc(Q);
  endtask

  task automatic i2c_stop;
    m_sda = 0;
    wc(Q);
    scl = 1;
    wc(Q);
    m_sda = 1;
    wc(Q);
  endtask

  task automatic wbyte(input logic [7:0] v, output logic ack);
    logic t;
    for (int i = 7; i >= 0; i--) bitc(v[i], t);
    bitc(1'b1, t);
    ack = ~t;
  endtask

  task automatic rbits(output logic [7:0] v);
    logic t;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      bitc(1'b1, t);
      v = {v[6:0], t};
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    wc(5);
    chk("rst_outs", {rx_data, rx_valid, rx_first, tx_req, busy, start_det, stop_det}, 0);
    chk("rst_sda", sda, 1);
    reset = 0;
    wc(10);
    // write 0x10, 0xA5
    snap;
    i2c_start;
    chk("t1_start", n_st - b_st, 1);
    wbyte(8'h90, a);
    chk("t1_ack_addr", a, 1);
    wbyte(8'h10, a);
    chk("t1_ack_d0", a, 1);
    wbyte(8'hA5, a);
    chk("t1_ack_d1", a, 1);
    chk("t1_rx_cnt", n_rx - b_rx, 2);
    chk("t1_rx0", rx_log[b_rx % 8], 8'h10);
    chk("t1_first0", rxf_log[b_rx % 8], 1);
    chk("t1_rx1", rx_log[(b_rx + 1) % 8], 8'hA5);
    chk("t1_first1", rxf_log[(b_rx + 1) % 8], 0);
    chk("t1_busy", busy, 1);
    i2c_stop;
    chk("t1_stop", n_sp - b_sp, 1);
    chk("t1_busy_off", busy, 0);
    // read 0x3C then 0xC3, ACK then NACK; tx_data changes after first capture
    snap;
    tx_data = 8'h3C;
    i2c_start;
    wbyte(8'h91, a);
    chk("t2_ack_addr", a, 1);
    tx_data = 8'hC3;
    rbits(d);
    chk("t2_rd0", d, 8'h3C);
    bitc(1'b0, s);
    rbits(d);
    chk("t2_rd1", d, 8'hC3);
    bitc(1'b1, s);
    chk("t2_txreq", n_tx - b_tx, 2);
    chk("t2_sda_rel", sda, 1);
    i2c_stop;
    // wrong address
    snap;
    i2c_start;
    wbyte(8'h92, a);
    chk("t3_nack_addr", a, 0);
    wbyte(8'h55, a);
    chk("t3_nack_d", a, 0);
    chk("t3_rx", n_rx - b_rx, 0);
    chk("t3_busy", busy, 0);
    chk("t3_start", n_st - b_st, 1);
    i2c_stop;
    // write pointer, repeated START, read
    snap;
    tx_data = 8'h5A;
    i2c_start;
    wbyte(8'h90, a);
    wbyte(8'h02, a);
    chk("t4_ack", a, 1);
    chk("t4_rx_cnt", n_rx - b_rx, 1);
    chk("t4_rx", rx_log[b_rx % 8], 8'h02);
    i2c_start;
    chk("t4_rstart", n_st - b_st, 2);
    wbyte(8'h91, a);
    chk("t4_ack_r", a, 1);
    chk("t4_txreq", n_tx - b_tx, 1);
    rbits(d);
    chk("t4_rd", d, 8'h5A);
    bitc(1'b1, s);
    i2c_stop;
    // partial byte then repeated START, and STOP right after address ACK
    snap;
    i2c_start;
    wbyte(8'h90, a);
    for (int i = 0; i < 4; i++) bitc(1'b1, s);
    i2c_start;
    i2c_stop;
    i2c_start;
    wbyte(8'h90, a);
    i2c_stop;
    chk("t7_rx", n_rx - b_rx, 0);
    chk("t7_tx", n_tx - b_tx, 0);
    // reset in the middle of bit 4 of a read
    tx_data = 8'h00;
    i2c_start;
    wbyte(8'h91, a);
    for (int i = 0; i < 3; i++) bitc(1'b1, s);
    m_sda = 1;
    wc(Q);
    scl = 1;
    wc(3);
    chk("t5_drive", sda, 0);
    #3 reset = 1;
    #1;
    chk("t5_sda_rel", sda, 1);
    chk("t5_outs", {rx_data, rx_valid, rx_first, tx_req, busy, start_det, stop_det}, 0);
    wc(3);
    reset = 0;
    wc(5);
    i2c_start;
    wbyte(8'h90, a);
    chk("t5_ack", a, 1);
    chk("t5_busy", busy, 1);
    i2c_stop;
    // sda moves while scl low, then glitches while scl high
    snap;
    scl = 0;
    wc(Q);
    m_sda = 0;
    wc(Q);
    m_sda = 1;
    wc(Q);
    scl = 1;
    wc(Q);
    chk("t6_low_act", (n_st - b_st) + (n_sp - b_sp), 0);
    m_sda = 0;
    wc(1);
    m_sda = 1;
    wc(10);
    chk("t6_glitch1", (n_st - b_st) + (n_sp - b_sp), 0);
    m_sda = 0;
    wc(2);
    m_sda = 1;
    wc(10);
    chk("t6_glitch2", (n_st - b_st) + (n_sp - b_sp), 0);
    m_sda = 0;
    wc(3);
    m_sda = 1;
    wc(10);
    chk("t6_pulse_st", n_st - b_st, 1);
    chk("t6_pulse_sp", n_sp - b_sp, 1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
